// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU main control FSM.
// Optional feature macro: MC_CTRL_ZEXT_EN (andi/ori with zero extension).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_EXT    = 2'b10;
  localparam logic [1:0] SRCB_EXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the main FSM (master) and the multi-cycle datapath (slave).
// Handshake: a memory access is presented by mem_read/mem_write held steady; the
// access completes in the cycle mem_ready=1, and nothing advances while it is 0.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       ext_op;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_op, illegal, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_op, illegal, state_o
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode from (state, opcode). Optional macro: MC_CTRL_ZEXT_EN.
// FETCH reports ir_write/pc_write unconditionally; the top gates them with mem_ready.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  output ctrl_t      cw
);

  logic [2:0] imm_alu_op;
  logic       imm_ext_op;

  always_comb begin
    imm_alu_op = ALU_ADD;
    imm_ext_op = 1'b0;
`ifdef MC_CTRL_ZEXT_EN
    if (opcode == OP_ANDI) begin
      imm_alu_op = ALU_AND;
      imm_ext_op = 1'b1;
    end else if (opcode == OP_ORI) begin
      imm_alu_op = ALU_OR;
      imm_ext_op = 1'b1;
    end
`else
    if (opcode != OP_ADDI) imm_alu_op = ALU_ADD;
`endif
  end

  always_comb begin
    cw = '0;
    unique case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_EXT_SH;
        cw.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_EXT;
        cw.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_EXEC_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_B;
        cw.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_EXT;
        cw.alu_op    = imm_alu_op;
        cw.ext_op    = imm_ext_op;
      end
      S_I_WB: begin
        cw.reg_write = 1'b1;
        cw.alu_op    = imm_alu_op;
        cw.ext_op    = imm_ext_op;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_B;
        cw.alu_op        = ALU_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle CPU: state register, next-state logic, sticky
// illegal flag. Optional macro: MC_CTRL_ZEXT_EN enables andi/ori decode.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);

  state_t state, state_nx;
  logic   illegal_q, illegal_set;
  ctrl_t  cw, cw_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    illegal_set = 1'b0;
    unique case (state)
      S_FETCH:    if (bus.mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_nx = S_MEM_ADDR;
          OP_RTYPE:     state_nx = S_EXEC_R;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
          OP_ADDI:      state_nx = S_EXEC_I;
`ifdef MC_CTRL_ZEXT_EN
          OP_ANDI, OP_ORI: state_nx = S_EXEC_I;
`endif
          default: begin
            state_nx    = S_HALT;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_nx = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_nx = S_MEM_WB;
      S_MEM_WB:   state_nx = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready) state_nx = S_FETCH;
      S_EXEC_R:   state_nx = S_R_WB;
      S_R_WB:     state_nx = S_FETCH;
      S_EXEC_I:   state_nx = S_I_WB;
      S_I_WB:     state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_JUMP:     state_nx = S_FETCH;
      S_HALT:     state_nx = S_HALT;
      default:    state_nx = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state  (state),
    .opcode (bus.opcode),
    .cw     (cw)
  );

  // IR/PC load only on the completing fetch cycle; rst blanks everything, even mid-wait.
  always_comb begin
    cw_out = cw;
    if (state == S_FETCH && !bus.mem_ready) begin
      cw_out.ir_write = 1'b0;
      cw_out.pc_write = 1'b0;
    end
    if (rst) cw_out = '0;
  end

  assign bus.pc_write      = cw_out.pc_write;
  assign bus.pc_write_cond = cw_out.pc_write_cond;
  assign bus.iord          = cw_out.iord;
  assign bus.mem_read      = cw_out.mem_read;
  assign bus.mem_write     = cw_out.mem_write;
  assign bus.ir_write      = cw_out.ir_write;
  assign bus.reg_dst       = cw_out.reg_dst;
  assign bus.mem_to_reg    = cw_out.mem_to_reg;
  assign bus.reg_write     = cw_out.reg_write;
  assign bus.alu_src_a     = cw_out.alu_src_a;
  assign bus.alu_src_b     = cw_out.alu_src_b;
  assign bus.alu_op        = cw_out.alu_op;
  assign bus.pc_source     = cw_out.pc_source;
  assign bus.ext_op        = cw_out.ext_op;
  assign bus.illegal       = illegal_q & ~rst;
  assign bus.state_o       = rst ? S_FETCH : state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboarded bench for mc_ctrl_fsm: a per-instruction step model pushes expected
// control words; a negedge monitor pops and compares. Honours MC_CTRL_ZEXT_EN.
module tb_mc_ctrl_fsm;

  localparam int W = 23;

  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5;
  localparam int EXEC_R = 6, R_WB = 7, EXEC_I = 8, I_WB = 9, BRANCH = 10, JUMP = 11, HALT = 12;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, J = 6'h02;
  localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D;

`ifdef MC_CTRL_ZEXT_EN
  localparam bit ZEXT = 1'b1;
`else
  localparam bit ZEXT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w, act_w;
  int           checks   = 0;
  int           failures = 0;
  logic         ill      = 1'b0;
  logic [5:0]   cur_op   = 6'h00;

  // reference model: control word for one cycle of a given instruction step
  function automatic logic [W-1:0] model(input int st, input logic [5:0] op,
                                         input logic mr, input logic il);
    logic       pcw, pcc, io, mrd, mwr, irw, rdst, m2r, rw, sa, ext;
    logic [1:0] sb, ps;
    logic [2:0] aop;
    logic [3:0] s4;
    pcw = 0; pcc = 0; io = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0; m2r = 0;
    rw = 0; sa = 0; ext = 0; sb = 2'b00; ps = 2'b00; aop = 3'b000;
    s4 = st[3:0];
    case (st)
      FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      DECODE:   begin sb = 2'b11; end
      MEM_ADDR: begin sa = 1; sb = 2'b10; end
      MEM_RD:   begin mrd = 1; io = 1; end
      MEM_WB:   begin rw = 1; m2r = 1; end
      MEM_WR:   begin mwr = 1; io = 1; end
      EXEC_R:   begin sa = 1; aop = 3'b010; end
      R_WB:     begin rw = 1; rdst = 1; end
      EXEC_I, I_WB: begin
        if (st == EXEC_I) begin sa = 1; sb = 2'b10; end
        else rw = 1;
        if (op == ANDI) begin aop = 3'b011; ext = 1; end
        else if (op == ORI) begin aop = 3'b100; ext = 1; end
      end
      BRANCH:   begin sa = 1; aop = 3'b001; pcc = 1; ps = 2'b01; end
      JUMP:     begin pcw = 1; ps = 2'b10; end
      default:  ;
    endcase
    return {s4, pcw, pcc, io, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, ps, ext, il};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    if (op == LW || op == SW || op == RT || op == BEQ || op == J || op == ADDI) return 1'b1;
    if (ZEXT && (op == ANDI || op == ORI)) return 1'b1;
    return 1'b0;
  endfunction

  // driver: apply one cycle of inputs and record what the DUT must show in it
  task automatic step(input int st, input logic mr, input logic rv);
    rst           = rv;
    bus.mem_ready = mr;
    bus.zero      = 1'($urandom_range(0, 1));
    exp_q.push_back(rv ? '0 : model(st, cur_op, mr, ill));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(FETCH, 1'($urandom_range(0, 1)), 1'b1);
    ill = 1'b0;
  endtask

  task automatic rnd_step(input int st);
    step(st, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait);
    cur_op     = op;
    bus.opcode = op;
    for (int i = 0; i < fwait; i++) step(FETCH, 1'b0, 1'b0);
    step(FETCH, 1'b1, 1'b0);
    rnd_step(DECODE);
    if (!is_legal(op)) begin
      ill = 1'b1;
      for (int i = 0; i < 4; i++) rnd_step(HALT);
      do_reset();
    end else if (op == LW) begin
      rnd_step(MEM_ADDR);
      for (int i = 0; i < mwait; i++) step(MEM_RD, 1'b0, 1'b0);
      step(MEM_RD, 1'b1, 1'b0);
      rnd_step(MEM_WB);
    end else if (op == SW) begin
      rnd_step(MEM_ADDR);
      for (int i = 0; i < mwait; i++) step(MEM_WR, 1'b0, 1'b0);
      step(MEM_WR, 1'b1, 1'b0);
    end else if (op == RT) begin
      rnd_step(EXEC_R);
      rnd_step(R_WB);
    end else if (op == BEQ) begin
      rnd_step(BRANCH);
    end else if (op == J) begin
      rnd_step(JUMP);
    end else begin
      rnd_step(EXEC_I);
      rnd_step(I_WB);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act_w = {bus.state_o, bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
               bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
               bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.ext_op,
               bus.illegal};
      checks++;
      if (act_w !== exp_w) begin
        failures++;
        $display("FAIL ctl_word t=%0t rst=%0b got=%h exp=%h (state got=%0d exp=%0d)",
                 $time, rst, act_w, exp_w, act_w[W-1 -: 4], exp_w[W-1 -: 4]);
      end
      if (bus.mem_read && bus.mem_write) begin
        failures++;
        $display("FAIL rd_wr_exclusive t=%0t got both=1 exp at most one", $time);
      end
    end
  end

  logic [5:0] op_tab[8];
  initial begin
    op_tab[0] = LW; op_tab[1] = SW; op_tab[2] = RT; op_tab[3] = BEQ;
    op_tab[4] = J;  op_tab[5] = ADDI; op_tab[6] = ANDI; op_tab[7] = ORI;

    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(FETCH, 1'b0, 1'b1);
    step(FETCH, 1'b1, 1'b1);

    // directed cases
    run_instr(LW, 0, 0);
    run_instr(ADDI, 3, 0);
    run_instr(BEQ, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(RT, 0, 0);
    run_instr(SW, 0, 2);
    run_instr(J, 1, 0);
    run_instr(ORI, 0, 0);
    run_instr(ANDI, 0, 0);

    // reset in the middle of a stalled lw read
    cur_op     = LW;
    bus.opcode = LW;
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, 1'b0, 1'b0);
    step(MEM_ADDR, 1'b0, 1'b0);
    step(MEM_RD, 1'b0, 1'b0);
    step(MEM_RD, 1'b0, 1'b0);
    do_reset();
    run_instr(LW, 0, 1);

    run_instr(6'h3F, 0, 0);
    run_instr(ADDI, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int fw, mw;
      if ($urandom_range(0, 9) < 8) op = op_tab[$urandom_range(0, 7)];
      else op = 6'($urandom_range(0, 63));
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(op, fw, mw);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Main control state machine for the multi-cycle CPU. It decodes the instruction opcode and sequences the shared datapath (PC, unified memory, instruction register, register file, sign/zero extension unit, ALU, PC source mux) through fetch, decode, execute, memory and write-back steps. It sits beside the datapath top level and drives every datapath select/enable line. It stalls on a memory-ready handshake.

## Interface
- No parameters; state and opcode encodings are package constants.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond  out  1 each  PC update enable / branch-conditional enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write, ir_write  out  1 each  memory strobes, IR load
- reg_dst, mem_to_reg, reg_write  out  1 each  register-file write controls
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ext_op  out  1  extension unit mode: 0 = sign, 1 = zero
- illegal  out  1  sticky unsupported-opcode flag
- state_o  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
- FETCH: mem_read=1, iord=0. Holds until mem_ready. In the mem_ready cycle it asserts ir_write=1 and pc_write=1, with alu_src_a=0, alu_src_b=01 and pc_source=00. It then moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (precomputes the branch target). Next state by opcode:
  - 100011 lw and 101011 sw → MEM_ADDR
  - 000000 → EXEC_R
  - 000100 beq → BRANCH
  - 000010 j → JUMP
  - 001000 addi, 001100 andi, 001101 ori → EXEC_I
  - any other opcode → HALT, and illegal is set
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000, ext_op=0. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10.
  - addi: alu_op=000, ext_op=0.
  - andi: alu_op=011, ext_op=1.
  - ori: alu_op=100, ext_op=1.
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. The opcode selects the same alu_op/ext_op as EXEC_I. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. The PC updates only when zero=1. Then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- HALT: terminal; all strobes 0. Only rst leaves it.
- Any output not listed for a state is 0.
- mem_read and mem_write are never asserted together.

## Timing
- Moore outputs, decoded combinationally from the state register; state updates on the rising clk edge.
- rst=1 at an edge sets state to FETCH and clears illegal. While rst is high, every output is forced to 0 and state_o reads FETCH. This applies mid-instruction, including during a pending memory wait.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. All outputs stay constant while waiting.
- ir_write and pc_write pulse for exactly one cycle per fetch, regardless of wait length.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Configuration
- MC_CTRL_ZEXT_EN defined: andi and ori decode as described above, with ext_op=1.
- Not defined: opcodes 001100 and 001101 go to HALT and set illegal. ext_op is tied to 0 and alu_op values 011/100 are never produced.

## Structure
- Package mc_ctrl_pkg holds:
  - the 4-bit state encodings (FETCH=0 … HALT=12);
  - the opcode constants;
  - the alu_op, alu_src_b and pc_source encodings.
- Sub-module mc_ctrl_outdec: a purely combinational map from (state, opcode) to the control word. The top level keeps the state register, next-state logic and the illegal flag.

## Test plan
- Reset mid-MEM_RD: rst for 1 cycle → next cycle state_o=FETCH, all outputs were 0 during rst, illegal=0.
- lw 0x8C… with mem_ready=1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB (5 cycles). reg_write=1 and mem_to_reg=1 only in cycle 5.
- FETCH with mem_ready low for 3 cycles → 3 extra FETCH cycles, then a single ir_write=1/pc_write=1 pulse.
- beq with zero=0, then zero=1 → pc_write_cond=1 and pc_source=01 in cycle 3 both times. The PC update is gated by zero=1.
- ori (0x34…) with the macro defined → EXEC_I shows alu_op=100, ext_op=1, alu_src_b=10. Without the macro → HALT and illegal=1.
- Opcode 0x3F → HALT and illegal=1. The FSM stays in HALT until rst.
